// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode encoding, FSM states
// and the divide-by-zero result.
package alu_arb_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_UDIV = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROTL = 4'h6;
    localparam logic [3:0] OP_ROTR = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hA;
    localparam logic [3:0] OP_NAND = 4'hB;
    localparam logic [3:0] OP_XOR  = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    // Wide enough for any supported WORDSIZE; users take the low bits.
    localparam logic [63:0] DIV0_RESULT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters (master) and the
// shared ALU arbiter (slave). Operands and opcodes are packed per requester.
interface alu_arbiter_if #(
    parameter int unsigned WORDSIZE      = 32,
    parameter int unsigned SEL_LINE_SIZE = 4,
    parameter int unsigned NUM_REQ       = 4
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*WORDSIZE-1:0]      req_a;
    logic [NUM_REQ*WORDSIZE-1:0]      req_b;
    logic [NUM_REQ*SEL_LINE_SIZE-1:0] req_sel;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [NUM_REQ-1:0]               rsp_ready;
    logic [WORDSIZE-1:0]              rsp_result;
    logic                             rsp_carry;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry
    );
endinterface

// File: rtl/alu_arb_core.sv
// Purely combinational ALU shared by all requesters of alu_arbiter.
module alu_arb_core
    import alu_arb_pkg::*;
#(
    parameter int unsigned WORDSIZE      = 32,
    parameter int unsigned SEL_LINE_SIZE = 4
) (
    input  logic [WORDSIZE-1:0]      a,
    input  logic [WORDSIZE-1:0]      b,
    input  logic [SEL_LINE_SIZE-1:0] sel,
    output logic [WORDSIZE-1:0]      result,
    output logic                     carry
);

    logic [WORDSIZE:0] sum;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        sum    = '0;
        case (sel)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WORDSIZE-1:0];
                carry  = sum[WORDSIZE];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_MUL:  result = a * b;
            OP_UDIV: result = (b == '0) ? DIV0_RESULT[WORDSIZE-1:0] : a / b;
            OP_SHL:  result = {a[WORDSIZE-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[WORDSIZE-1:1]};
            OP_ROTL: result = {a[WORDSIZE-2:0], a[WORDSIZE-1]};
            OP_ROTR: result = {a[0], a[WORDSIZE-1:1]};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result[0] = (a > b);
            OP_EQ:   result[0] = (a == b);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared ALU core (IDLE/EXEC/RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WORDSIZE      = 32,
    parameter int unsigned SEL_LINE_SIZE = 4,
    parameter int unsigned NUM_REQ       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic         busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t state_q, state_d;

    logic [WORDSIZE-1:0]      a_q, b_q, res_q;
    logic [SEL_LINE_SIZE-1:0] sel_q;
    logic                     carry_q;
    logic [IDX_W-1:0]         owner_q;

    logic [WORDSIZE-1:0]      core_result;
    logic                     core_carry;

    logic [WORDSIZE-1:0]      a_arr   [NUM_REQ];
    logic [WORDSIZE-1:0]      b_arr   [NUM_REQ];
    logic [SEL_LINE_SIZE-1:0] sel_arr [NUM_REQ];

    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] idx;
    logic             accept;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g]   = bus.req_a[g*WORDSIZE +: WORDSIZE];
        assign b_arr[g]   = bus.req_b[g*WORDSIZE +: WORDSIZE];
        assign sel_arr[g] = bus.req_sel[g*SEL_LINE_SIZE +: SEL_LINE_SIZE];
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam int unsigned CW = IDX_W + 1;
    logic [IDX_W-1:0] ptr_q;
    logic [CW-1:0]    cand;
`endif

    // First valid requester in scan order; the scan starts at the pointer in
    // round-robin mode and at index 0 otherwise.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        cand   = '0;
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
            idx = cand[IDX_W-1:0];
`else
            idx = IDX_W'(k);
`endif
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        accept        = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                if (found && rst_n) begin
                    bus.req_ready[winner] = 1'b1;
                    accept                = 1'b1;
                    state_d               = ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy    = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                busy                   = 1'b1;
                bus.rsp_valid[owner_q] = 1'b1;
                if (bus.rsp_ready[owner_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            owner_q <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= a_arr[winner];
                b_q     <= b_arr[winner];
                sel_q   <= sel_arr[winner];
                owner_q <= winner;
            end
            if (state_q == ST_EXEC) begin
                res_q   <= core_result;
                carry_q <= core_carry;
            end
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    assign bus.rsp_result = res_q;
    assign bus.rsp_carry  = carry_q;

    alu_arb_core #(
        .WORDSIZE      (WORDSIZE),
        .SEL_LINE_SIZE (SEL_LINE_SIZE)
    ) u_core (
        .a      (a_q),
        .b      (b_q),
        .sel    (sel_q),
        .result (core_result),
        .carry  (core_carry)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: opcode vector table plus hand-written
// arbitration, backpressure and reset-in-flight sequences.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned WS = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned NR = 4;

    typedef struct {
        logic [1:0]  idx;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        logic        ec;
    } vec_t;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] result;
        logic        carry;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    logic [31:0] ta  [4];
    logic [31:0] tbv [4];
    logic [3:0]  ts  [4];

    vec_t vecs[$];
    exp_t sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit ok;

    logic [31:0] sweep_exp [16] = '{
        32'h80000004, 32'h7FFFFFFE, 32'h80000003, 32'h2AAAAAAB,
        32'h00000002, 32'h40000000, 32'h00000003, 32'hC0000000,
        32'h00000001, 32'h80000003, 32'h7FFFFFFC, 32'hFFFFFFFE,
        32'h80000002, 32'h7FFFFFFD, 32'h00000001, 32'h00000000
    };

    always #5 clk = ~clk;

    alu_arbiter_if #(.WORDSIZE(WS), .SEL_LINE_SIZE(SW), .NUM_REQ(NR)) bus ();

    assign bus.req_a   = {ta[3], ta[2], ta[1], ta[0]};
    assign bus.req_b   = {tbv[3], tbv[2], tbv[1], tbv[0]};
    assign bus.req_sel = {ts[3], ts[2], ts[1], ts[0]};

    alu_arbiter #(.WORDSIZE(WS), .SEL_LINE_SIZE(SW), .NUM_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] idx, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic ec);
        vec_t v;
        v.idx = idx; v.sel = sel; v.a = a; v.b = b; v.er = er; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [1:0] owner, input logic [31:0] result, input logic carry);
        exp_t e;
        e.owner = owner; e.result = result; e.carry = carry;
        sb.push_back(e);
    endtask

    task automatic check_rsp();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("rsp_owner", {28'b0, bus.rsp_valid}, {28'b0, oh(e.owner)});
            check("rsp_result", bus.rsp_result, e.result);
            check("rsp_carry", {31'b0, bus.rsp_carry}, {31'b0, e.carry});
        end
    endtask

    // Caller is just after a falling edge; samples now, then once per cycle.
    task automatic wait_ready(input logic [1:0] idx, output bit got);
        int unsigned n = 0;
        #1;
        while (!bus.req_ready[idx] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        got = bus.req_ready[idx];
        check("accept_ready", {31'b0, bus.req_ready[idx]}, 32'd1);
    endtask

    task automatic wait_rsp(output bit got);
        int unsigned n = 0;
        while (bus.rsp_valid == '0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        got = (bus.rsp_valid != '0);
        check("rsp_arrival", {31'b0, got}, 32'd1);
    endtask

    task automatic collect();
        bit got;
        wait_rsp(got);
        if (got) check_rsp();
        else if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic run_op(input vec_t v);
        bit got;
        @(negedge clk);
        ta[v.idx] = v.a; tbv[v.idx] = v.b; ts[v.idx] = v.sel;
        bus.req_valid[v.idx] = 1'b1;
        push_exp(v.idx, v.er, v.ec);
        wait_ready(v.idx, got);
        if (!got) begin
            bus.req_valid[v.idx] = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(negedge clk);
        bus.req_valid[v.idx] = 1'b0;
        #1;
        check("exec_rsp_valid", {28'b0, bus.rsp_valid}, 32'd0);
        check("exec_busy", {31'b0, busy}, 32'd1);
        check("exec_req_ready", {28'b0, bus.req_ready}, 32'd0);
        @(negedge clk); #1;
        check("latency", {28'b0, bus.rsp_valid}, {28'b0, oh(v.idx)});
        collect();
        bus.rsp_ready[v.idx] = 1'b1;
        @(negedge clk);
        bus.rsp_ready = '0;
        #1;
        check("post_hs_busy", {31'b0, busy}, 32'd0);
        check("post_hs_rsp_valid", {28'b0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_w;
        for (int i = 0; i < 4; i++) begin
            ta[i] = '0; tbv[i] = '0; ts[i] = '0;
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;

        add_vec(2'd0, OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        add_vec(2'd2, OP_UDIV, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b0);
        add_vec(2'd2, OP_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b1);
        for (int unsigned i = 0; i < 16; i++)
            add_vec(2'(i), 4'(i), 32'h80000001, 32'h00000003, sweep_exp[i], 1'b0);
        add_vec(2'd3, OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
        add_vec(2'd1, OP_SUB,  32'd5,        32'd5,        32'h00000000, 1'b0);
        add_vec(2'd1, OP_SUB,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b1);
        add_vec(2'd0, OP_EQ,   32'd5,        32'd5,        32'h00000001, 1'b0);
        add_vec(2'd3, OP_UDIV, 32'd7,        32'd2,        32'h00000003, 1'b0);
        add_vec(2'd2, OP_GT,   32'd3,        32'd5,        32'h00000000, 1'b0);
        add_vec(2'd0, OP_SHR,  32'h80000000, 32'd0,        32'h40000000, 1'b0);

        // reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_req_ready", {28'b0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {28'b0, bus.rsp_valid}, 32'd0);
        check("rst_result", bus.rsp_result, 32'd0);
        check("rst_carry", {31'b0, bus.rsp_carry}, 32'd0);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < vecs.size(); i++) run_op(vecs[i]);

        // all requesters valid continuously; each returns its own index
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ta[i] = 32'(i); tbv[i] = '0; ts[i] = OP_ADD;
        end
        bus.rsp_ready = '1;
        bus.req_valid = '1;
        for (int unsigned g = 0; g < 5; g++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_w = 2'(g);
`else
            exp_w = 2'd0;
`endif
            wait_ready(exp_w, ok);
            check("grant_onehot", $countones(bus.req_ready), 32'd1);
            check("grant_order", {28'b0, bus.req_ready}, {28'b0, oh(exp_w)});
            push_exp(exp_w, 32'(exp_w), 1'b0);
            collect();
        end
        bus.req_valid = '0;
        @(negedge clk);
        bus.rsp_ready = '0;
        @(negedge clk);

        // owner stalls the response while others are valid/ready
        ta[1] = 32'hF0F0F0F0; tbv[1] = 32'h0FF00FF0; ts[1] = OP_XOR;
        bus.req_valid[1] = 1'b1;
        push_exp(2'd1, 32'hFF00FF00, 1'b0);
        wait_ready(2'd1, ok);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        ta[2] = 32'hFFFF0000; tbv[2] = 32'h0F0F0F0F; ts[2] = OP_AND;
        bus.req_valid[2] = 1'b1;
        bus.rsp_ready = 4'b1101;
        #1;
        check("exec_no_grant", {28'b0, bus.req_ready}, 32'd0);
        collect();
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("stall_rsp_valid", {28'b0, bus.rsp_valid}, 32'b0010);
            check("stall_result", bus.rsp_result, 32'hFF00FF00);
            check("stall_req_ready", {28'b0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready[1] = 1'b1;
        push_exp(2'd2, 32'h0F0F0000, 1'b0);
        @(negedge clk); #1;
        check("hs_busy", {31'b0, busy}, 32'd0);
        check("hs_rsp_valid", {28'b0, bus.rsp_valid}, 32'd0);
        check("waiting_grant", {28'b0, bus.req_ready}, 32'b0100);
        bus.rsp_ready = '0;
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        #1;
        collect();
        bus.rsp_ready[2] = 1'b1;
        @(negedge clk);
        bus.rsp_ready = '0;

        // reset while an operation is in EXEC
        @(negedge clk);
        ta[2] = 32'h12345678; tbv[2] = 32'h1; ts[2] = OP_ADD;
        bus.req_valid[2] = 1'b1;
        wait_ready(2'd2, ok);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        #1;
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_rsp_valid", {28'b0, bus.rsp_valid}, 32'd0);
        check("midrst_req_ready", {28'b0, bus.req_ready}, 32'd0);
        check("midrst_result", bus.rsp_result, 32'd0);
        check("midrst_carry", {31'b0, bus.rsp_carry}, 32'd0);
        rst_n = 1'b1;
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check("no_rsp_after_reset", {28'b0, bus.rsp_valid}, 32'd0);
        end
        bus.req_valid = '1;
        #1;
        check("ptr_after_reset", {28'b0, bus.req_ready}, 32'b0001);
        bus.req_valid = '0;
        @(negedge clk); #1;
        check("idle_after_drop", {31'b0, busy}, 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
